// File: rtl/sn_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sn_bus_if
//  Description : Host write-strobe bus of the PSG sound core. The host drives
//                nCE/nWE/D and watches READY to pace its writes.
//  Ports       : nCE   - chip enable, active low    (host -> chip)
//                nWE   - write enable, active low   (host -> chip)
//                D     - write data byte            (host -> chip)
//                READY - 1 = ready, 0 = busy        (chip -> host)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sn_bus_if;
  logic       nCE;
  logic       nWE;
  logic [7:0] D;
  logic       READY;

  modport master (output nCE, output nWE, output D, input READY);
  modport slave  (input nCE, input nWE, input D, output READY);
endinterface
`default_nettype wire

// File: rtl/sn_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sn_bus_responder
//  Description : Chip-side write-bus responder for the PSG sound core. Accepts
//                byte writes on the nCE/nWE/D strobe bus, paces the host with
//                READY and decodes SN76489-style latch/data bytes into three
//                10-bit tone periods, four attenuators and a noise control.
//  Parameters  : BUSY_CYCLES - CLK cycles READY stays low per write (1..255)
//  Ports       : CLK, RST (async, active high)
//                bus         - sn_bus_if slave (nCE, nWE, D, READY)
//                tone0..2    - tone period registers (10 bit)
//                atten0..3   - attenuators, 0 = loudest, F = off
//                noise_ctrl  - noise mode/rate
//                noise_reset - one-cycle pulse on each noise_ctrl write
//                wr_strobe   - one-cycle pulse when a byte is applied
//  Options     : define SN_BUS_INPUT_SYNC_EN to pass nCE/nWE through 2-flop
//                synchronizers (accept-to-READY-low latency 3 CLK instead of 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module sn_bus_responder #(
  parameter int BUSY_CYCLES = 32
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  sn_bus_if.slave         bus,
  output logic [9:0]      tone0,
  output logic [9:0]      tone1,
  output logic [9:0]      tone2,
  output logic [3:0]      atten0,
  output logic [3:0]      atten1,
  output logic [3:0]      atten2,
  output logic [3:0]      atten3,
  output logic [2:0]      noise_ctrl,
  output logic            noise_reset,
  output logic            wr_strobe
);

  localparam logic [7:0] c_count_load = 8'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_count, w_count_nxt;
  logic        w_accept;
  logic        w_ready;
  logic        w_strobe_n;
  logic        r_strobe_prev;
  logic        w_strobe_fall;

  logic        r_pending;
  logic [7:0]  r_data;
  logic [2:0]  r_latch;      // {chan[1:0], type}
  logic [2:0]  w_sel;
  logic [9:0]  r_tone0, r_tone1, r_tone2;
  logic [3:0]  r_atten [4];
  logic [2:0]  r_noise;
  logic        r_noise_reset;
  logic        r_wr_strobe;

  // --------------------------------------------------------------------------
  // Strobe conditioning
  // --------------------------------------------------------------------------
`ifdef SN_BUS_INPUT_SYNC_EN
  logic [1:0] r_nce_sync;
  logic [1:0] r_nwe_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_nce_sync <= 2'b11;
      r_nwe_sync <= 2'b11;
    end else begin
      r_nce_sync <= {r_nce_sync[0], bus.nCE};
      r_nwe_sync <= {r_nwe_sync[0], bus.nWE};
    end
  end

  assign w_strobe_n = r_nce_sync[1] | r_nwe_sync[1];
`else
  assign w_strobe_n = bus.nCE | bus.nWE;
`endif

  assign w_strobe_fall = r_strobe_prev & ~w_strobe_n;

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    w_ready     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_strobe_fall) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
          w_count_nxt = c_count_load;
        end
      end
      ST_BUSY: begin
        w_ready = 1'b0;
        if (r_count == 8'd0) begin
          // A strobe still held low must be released before the next write
          w_state_nxt = w_strobe_n ? ST_IDLE : ST_WAIT_REL;
        end else begin
          w_count_nxt = r_count - 8'd1;
        end
      end
      ST_WAIT_REL: begin
        if (w_strobe_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // READY is decoded from state so reset drives it high asynchronously
  assign bus.READY = w_ready;

  // --------------------------------------------------------------------------
  // Capture and register-file decode
  // --------------------------------------------------------------------------
  // Latch bytes carry their own target; data bytes reuse the latched one.
  assign w_sel = r_data[7] ? r_data[6:4] : r_latch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_strobe_prev <= 1'b1;
      r_pending     <= 1'b0;
      r_data        <= 8'd0;
      r_latch       <= 3'd0;
      r_tone0       <= 10'd0;
      r_tone1       <= 10'd0;
      r_tone2       <= 10'd0;
      r_atten[0]    <= 4'hF;
      r_atten[1]    <= 4'hF;
      r_atten[2]    <= 4'hF;
      r_atten[3]    <= 4'hF;
      r_noise       <= 3'd0;
      r_noise_reset <= 1'b0;
      r_wr_strobe   <= 1'b0;
    end else begin
      r_strobe_prev <= w_strobe_n;
      r_pending     <= w_accept;
      r_noise_reset <= 1'b0;
      r_wr_strobe   <= 1'b0;
      if (w_accept) begin
        r_data <= bus.D;
      end
      if (r_pending) begin
        r_wr_strobe <= 1'b1;
        if (r_data[7]) begin
          r_latch <= r_data[6:4];
        end
        if (w_sel[0]) begin
          r_atten[w_sel[2:1]] <= r_data[3:0];
        end else begin
          case (w_sel[2:1])
            2'd0: begin
              if (r_data[7]) r_tone0[3:0] <= r_data[3:0];
              else           r_tone0[9:4] <= r_data[5:0];
            end
            2'd1: begin
              if (r_data[7]) r_tone1[3:0] <= r_data[3:0];
              else           r_tone1[9:4] <= r_data[5:0];
            end
            2'd2: begin
              if (r_data[7]) r_tone2[3:0] <= r_data[3:0];
              else           r_tone2[9:4] <= r_data[5:0];
            end
            default: begin
              r_noise       <= r_data[2:0];
              r_noise_reset <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign tone0       = r_tone0;
  assign tone1       = r_tone1;
  assign tone2       = r_tone2;
  assign atten0      = r_atten[0];
  assign atten1      = r_atten[1];
  assign atten2      = r_atten[2];
  assign atten3      = r_atten[3];
  assign noise_ctrl  = r_noise;
  assign noise_reset = r_noise_reset;
  assign wr_strobe   = r_wr_strobe;

endmodule
`default_nettype wire
